wb_regfile: RTL and testbench
=============================

WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 Parameter DATA_W, default 32, datapath and register width.
REQ-002 Parameter PC_W, default 8, width of the pc4 return-address field.
REQ-003 Parameter CNT_W, default 16, width of the writeback commit counter.
REQ-004 clk  input  1  single clock; all state updates on posedge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 RegWrite_in  input  1  writeback enable from the MEM/WB stage.
REQ-007 WBSel_in  input  2  writeback source select.
REQ-008 alu_in  input  DATA_W  ALU result.
REQ-009 dmem_in  input  DATA_W  load data.
REQ-010 pc4_in  input  PC_W  return address (PC+4).
REQ-011 rd_in  input  5  destination register index.
REQ-012 rs1_addr, rs2_addr  input  5 each  decode-stage read indices.
REQ-013 rs1_data, rs2_data  output  DATA_W each  read data.
REQ-014 wb_data  output  DATA_W  selected writeback value, combinational.
REQ-015 wb_we  output  1  effective write strobe: RegWrite_in and rd_in != 0.
REQ-016 wb_count  output  CNT_W  number of committed register writes.

Function
REQ-017 wb_data SHALL be alu_in for WBSel 00, dmem_in for 01, pc4_in zero-extended to DATA_W for 10, and all-zero for 11.
REQ-018 Storage SHALL be 32 registers x DATA_W, x1..x31 writable; x0 SHALL always read 0.
REQ-019 When wb_we=1, reg[rd_in] SHALL take wb_data at posedge clk; write latency 1 cycle.
REQ-020 RegWrite_in=1 with rd_in=0 SHALL leave all registers and wb_count unchanged; wb_we=0.
REQ-021 WBSel 11 with wb_we=1 SHALL write zero and count as a commit.
REQ-022 rs1_data/rs2_data SHALL be combinational in rs*_addr; the two ports are independent and may address the same register.
REQ-023 wb_count SHALL increment by 1 on every posedge with wb_we=1 and wrap from all-ones to 0.
REQ-024 Inputs SHALL need no handshake: one writeback per cycle, no stall or backpressure.

Reset
REQ-025 rst_n low SHALL immediately, independent of clk, clear all registers and wb_count to 0.
REQ-026 During reset, rs1_data, rs2_data and wb_count SHALL read 0; wb_data and wb_we stay combinational.
REQ-027 Writes presented in the cycle rst_n deasserts SHALL take effect on the first posedge with rst_n high.
REQ-028 Reset asserted between two writes SHALL discard the earlier write; no state survives reset.

Configuration
REQ-029 Macro WB_REGFILE_BYPASS_EN, when defined, SHALL forward wb_data onto rs1_data/rs2_data whenever wb_we=1 and rd_in equals that port's address (write-before-read, same cycle).
REQ-030 Without WB_REGFILE_BYPASS_EN, reads SHALL return the stored value; a same-cycle write becomes visible the following cycle.
REQ-031 Address 0 SHALL read 0 in both configurations, even when rd_in=0 with RegWrite_in=1.

Verification
REQ-032 Reset: rst_n=0 mid-cycle after writing x5=0x1234 -> rs1_data at x5 reads 0 immediately, wb_count=0.
REQ-033 Select: rd=3, RegWrite=1, WBSel=10, pc4=0xA4, next cycle rs1=3 -> 0x000000A4; WBSel=11 write -> x3 reads 0, wb_count +2 total.
REQ-034 x0: RegWrite=1, rd=0, alu=0xFFFFFFFF -> wb_we=0, rs2=0 reads 0, wb_count unchanged.
REQ-035 Bypass: x7=0x11, same cycle write x7=0x22 (WBSel=01), rs1=rs2=7 -> 0x22 with macro, 0x11 without; 0x22 next cycle in both.
REQ-036 Counter wrap: force 65535 committed writes then one more (CNT_W=16) -> wb_count 0xFFFF then 0x0000.
REQ-037 Back-to-back: writes x1=1, x1=2, x2=3 on consecutive cycles -> reads after each edge return 1, 2, then x1=2, x2=3.

Source files
------------

// File: rtl/wb_regfile_if.sv
// Writeback/read bundle for wb_regfile: writeback source inputs, read ports and commit status.
interface wb_regfile_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PC_W   = 8,
  parameter int unsigned CNT_W  = 16
);
  logic              RegWrite_in;
  logic [1:0]        WBSel_in;
  logic [DATA_W-1:0] alu_in;
  logic [DATA_W-1:0] dmem_in;
  logic [PC_W-1:0]   pc4_in;
  logic [4:0]        rd_in;
  logic [4:0]        rs1_addr;
  logic [4:0]        rs2_addr;
  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;
  logic [DATA_W-1:0] wb_data;
  logic              wb_we;
  logic [CNT_W-1:0]  wb_count;

  modport master (
    output RegWrite_in, WBSel_in, alu_in, dmem_in, pc4_in, rd_in, rs1_addr, rs2_addr,
    input  rs1_data, rs2_data, wb_data, wb_we, wb_count
  );

  modport slave (
    input  RegWrite_in, WBSel_in, alu_in, dmem_in, pc4_in, rd_in, rs1_addr, rs2_addr,
    output rs1_data, rs2_data, wb_data, wb_we, wb_count
  );
endinterface

// File: rtl/wb_regfile.sv
// 32-entry register file with writeback source mux and commit counter.
// Define WB_REGFILE_BYPASS_EN to forward same-cycle writeback data onto the read ports.
module wb_regfile #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PC_W   = 8,
  parameter int unsigned CNT_W  = 16
) (
  input logic        clk,
  input logic        rst_n,
  wb_regfile_if.slave bus
);

  logic [DATA_W-1:0] regs [1:31];
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] wb_data;
  logic              wb_we;
  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;

  always_comb begin
    wb_data = '0;
    unique case (bus.WBSel_in)
      2'b00:   wb_data = bus.alu_in;
      2'b01:   wb_data = bus.dmem_in;
      2'b10:   wb_data = DATA_W'(bus.pc4_in);
      default: wb_data = '0;
    endcase
  end

  assign wb_we = bus.RegWrite_in && (bus.rd_in != 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 1; i < 32; i++) regs[i] <= '0;
      count <= '0;
    end else if (wb_we) begin
      regs[bus.rd_in] <= wb_data;
      count           <= count + 1'b1;
    end
  end

  always_comb begin
    rs1_data = '0;
    if (bus.rs1_addr != 5'd0) begin
      rs1_data = regs[bus.rs1_addr];
`ifdef WB_REGFILE_BYPASS_EN
      if (wb_we && (bus.rd_in == bus.rs1_addr)) rs1_data = wb_data;
`endif
    end
  end

  always_comb begin
    rs2_data = '0;
    if (bus.rs2_addr != 5'd0) begin
      rs2_data = regs[bus.rs2_addr];
`ifdef WB_REGFILE_BYPASS_EN
      if (wb_we && (bus.rd_in == bus.rs2_addr)) rs2_data = wb_data;
`endif
    end
  end

  assign bus.wb_data  = wb_data;
  assign bus.wb_we    = wb_we;
  assign bus.wb_count = count;
  assign bus.rs1_data = rs1_data;
  assign bus.rs2_data = rs2_data;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile; expected values are hand-computed constants.
module tb_wb_regfile;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned PC_W   = 8;
  localparam int unsigned CNT_W  = 16;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  wb_regfile_if #(.DATA_W(DATA_W), .PC_W(PC_W), .CNT_W(CNT_W)) bus ();

  wb_regfile #(.DATA_W(DATA_W), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [1:0] sel, input logic [31:0] alu,
                       input logic [31:0] dmem, input logic [7:0] pc4, input logic [4:0] rd);
    bus.RegWrite_in = we;
    bus.WBSel_in    = sel;
    bus.alu_in      = alu;
    bus.dmem_in     = dmem;
    bus.pc4_in      = pc4;
    bus.rd_in       = rd;
  endtask

  task automatic idle();
    drive(1'b0, 2'b00, 32'h0, 32'h0, 8'h0, 5'd0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.rs1_addr = 5'd5;
    bus.rs2_addr = 5'd9;
    drive(1'b1, 2'b00, 32'h0000ABCD, 32'h0, 8'h0, 5'd5);
    #1;
    tests_run++;
    if (bus.rs1_data !== 32'h0) begin tests_failed++; $display("FAIL reset_rs1: got %h expected %h", bus.rs1_data, 32'h0); end
    tests_run++;
    if (bus.wb_count !== 16'h0) begin tests_failed++; $display("FAIL reset_count: got %h expected %h", bus.wb_count, 16'h0); end
    tests_run++;
    if (bus.wb_data !== 32'h0000ABCD) begin tests_failed++; $display("FAIL reset_wb_data_comb: got %h expected %h", bus.wb_data, 32'h0000ABCD); end
    tests_run++;
    if (bus.wb_we !== 1'b1) begin tests_failed++; $display("FAIL reset_wb_we_comb: got %b expected 1", bus.wb_we); end
    // Write pending while reset releases mid-cycle lands on the first high edge.
    @(negedge clk);
    drive(1'b1, 2'b01, 32'h0, 32'h00000055, 8'h0, 5'd9);
    #2 rst_n = 1'b1;
    tick();
    idle();
    #1;
    tests_run++;
    if (bus.rs2_data !== 32'h55) begin tests_failed++; $display("FAIL release_write: got %h expected %h", bus.rs2_data, 32'h55); end
    tests_run++;
    if (bus.wb_count !== 16'd1) begin tests_failed++; $display("FAIL release_count: got %h expected %h", bus.wb_count, 16'd1); end
    drive(1'b1, 2'b00, 32'h00001234, 32'h0, 8'h0, 5'd5);
    tick();
    idle();
    tests_run++;
    if (bus.rs1_data !== 32'h1234) begin tests_failed++; $display("FAIL x5_before_reset: got %h expected %h", bus.rs1_data, 32'h1234); end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus.rs1_data !== 32'h0) begin tests_failed++; $display("FAIL x5_async_clear: got %h expected %h", bus.rs1_data, 32'h0); end
    tests_run++;
    if (bus.wb_count !== 16'h0) begin tests_failed++; $display("FAIL count_async_clear: got %h expected %h", bus.wb_count, 16'h0); end
    tests_run++;
    if (bus.rs2_data !== 32'h0) begin tests_failed++; $display("FAIL x9_async_clear: got %h expected %h", bus.rs2_data, 32'h0); end
    #1 rst_n = 1'b1;
    // Reset between two writes: the first is lost.
    drive(1'b1, 2'b00, 32'h7, 32'h0, 8'h0, 5'd4);
    tick();
    idle();
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    drive(1'b1, 2'b00, 32'h8, 32'h0, 8'h0, 5'd6);
    tick();
    idle();
    bus.rs1_addr = 5'd4;
    bus.rs2_addr = 5'd6;
    #1;
    tests_run++;
    if (bus.rs1_data !== 32'h0) begin tests_failed++; $display("FAIL reset_discard_x4: got %h expected %h", bus.rs1_data, 32'h0); end
    tests_run++;
    if (bus.rs2_data !== 32'h8) begin tests_failed++; $display("FAIL after_reset_x6: got %h expected %h", bus.rs2_data, 32'h8); end
    tests_run++;
    if (bus.wb_count !== 16'd1) begin tests_failed++; $display("FAIL after_reset_count: got %h expected %h", bus.wb_count, 16'd1); end
  endtask

  task automatic test_select();
    // wb_count is 1 on entry
    drive(1'b1, 2'b00, 32'hDEAD0001, 32'hBEEF0002, 8'hA4, 5'd3);
    #1;
    tests_run++;
    if (bus.wb_data !== 32'hDEAD0001) begin tests_failed++; $display("FAIL sel00: got %h expected %h", bus.wb_data, 32'hDEAD0001); end
    bus.WBSel_in = 2'b01;
    #1;
    tests_run++;
    if (bus.wb_data !== 32'hBEEF0002) begin tests_failed++; $display("FAIL sel01: got %h expected %h", bus.wb_data, 32'hBEEF0002); end
    bus.WBSel_in = 2'b10;
    #1;
    tests_run++;
    if (bus.wb_data !== 32'h000000A4) begin tests_failed++; $display("FAIL sel10: got %h expected %h", bus.wb_data, 32'h000000A4); end
    tick();
    idle();
    bus.rs1_addr = 5'd3;
    #1;
    tests_run++;
    if (bus.rs1_data !== 32'h000000A4) begin tests_failed++; $display("FAIL x3_pc4: got %h expected %h", bus.rs1_data, 32'h000000A4); end
    drive(1'b1, 2'b11, 32'hDEAD0001, 32'hBEEF0002, 8'hA4, 5'd3);
    #1;
    tests_run++;
    if (bus.wb_data !== 32'h0) begin tests_failed++; $display("FAIL sel11: got %h expected %h", bus.wb_data, 32'h0); end
    tick();
    idle();
    #1;
    tests_run++;
    if (bus.rs1_data !== 32'h0) begin tests_failed++; $display("FAIL x3_zero_write: got %h expected %h", bus.rs1_data, 32'h0); end
    tests_run++;
    if (bus.wb_count !== 16'd3) begin tests_failed++; $display("FAIL select_count: got %h expected %h", bus.wb_count, 16'd3); end
  endtask

  task automatic test_x0();
    bus.rs1_addr = 5'd0;
    bus.rs2_addr = 5'd0;
    drive(1'b1, 2'b00, 32'hFFFFFFFF, 32'h0, 8'h0, 5'd0);
    #1;
    tests_run++;
    if (bus.wb_we !== 1'b0) begin tests_failed++; $display("FAIL x0_wb_we: got %b expected 0", bus.wb_we); end
    tests_run++;
    if (bus.rs2_data !== 32'h0) begin tests_failed++; $display("FAIL x0_rs2_same_cycle: got %h expected %h", bus.rs2_data, 32'h0); end
    tick();
    idle();
    #1;
    tests_run++;
    if (bus.rs2_data !== 32'h0) begin tests_failed++; $display("FAIL x0_rs2_after: got %h expected %h", bus.rs2_data, 32'h0); end
    tests_run++;
    if (bus.wb_count !== 16'd3) begin tests_failed++; $display("FAIL x0_count: got %h expected %h", bus.wb_count, 16'd3); end
  endtask

  task automatic test_bypass();
    logic [31:0] exp_same;
`ifdef WB_REGFILE_BYPASS_EN
    exp_same = 32'h22;
`else
    exp_same = 32'h11;
`endif
    drive(1'b1, 2'b00, 32'h11, 32'h0, 8'h0, 5'd7);
    tick();
    drive(1'b1, 2'b01, 32'h0, 32'h22, 8'h0, 5'd7);
    bus.rs1_addr = 5'd7;
    bus.rs2_addr = 5'd7;
    #1;
    tests_run++;
    if (bus.rs1_data !== exp_same) begin tests_failed++; $display("FAIL bypass_rs1: got %h expected %h", bus.rs1_data, exp_same); end
    tests_run++;
    if (bus.rs2_data !== exp_same) begin tests_failed++; $display("FAIL bypass_rs2: got %h expected %h", bus.rs2_data, exp_same); end
    tick();
    idle();
    #1;
    tests_run++;
    if (bus.rs1_data !== 32'h22) begin tests_failed++; $display("FAIL bypass_next_rs1: got %h expected %h", bus.rs1_data, 32'h22); end
    tests_run++;
    if (bus.rs2_data !== 32'h22) begin tests_failed++; $display("FAIL bypass_next_rs2: got %h expected %h", bus.rs2_data, 32'h22); end
  endtask

  task automatic test_back_to_back();
    bus.rs1_addr = 5'd1;
    bus.rs2_addr = 5'd2;
    drive(1'b1, 2'b00, 32'd1, 32'h0, 8'h0, 5'd1);
    tick();
    tests_run++;
    if (bus.rs1_data !== 32'd1) begin tests_failed++; $display("FAIL b2b_first: got %h expected %h", bus.rs1_data, 32'd1); end
    drive(1'b1, 2'b00, 32'd2, 32'h0, 8'h0, 5'd1);
    tick();
    tests_run++;
    if (bus.rs1_data !== 32'd2) begin tests_failed++; $display("FAIL b2b_second: got %h expected %h", bus.rs1_data, 32'd2); end
    drive(1'b1, 2'b01, 32'h0, 32'd3, 8'h0, 5'd2);
    tick();
    idle();
    #1;
    tests_run++;
    if (bus.rs1_data !== 32'd2) begin tests_failed++; $display("FAIL b2b_x1: got %h expected %h", bus.rs1_data, 32'd2); end
    tests_run++;
    if (bus.rs2_data !== 32'd3) begin tests_failed++; $display("FAIL b2b_x2: got %h expected %h", bus.rs2_data, 32'd3); end
  endtask

  task automatic test_counter_wrap();
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    tests_run++;
    if (bus.wb_count !== 16'h0) begin tests_failed++; $display("FAIL wrap_start: got %h expected %h", bus.wb_count, 16'h0); end
    bus.rs1_addr = 5'd10;
    drive(1'b1, 2'b00, 32'h0000C0DE, 32'h0, 8'h0, 5'd10);
    repeat (65535) tick();
    tests_run++;
    if (bus.wb_count !== 16'hFFFF) begin tests_failed++; $display("FAIL wrap_full: got %h expected %h", bus.wb_count, 16'hFFFF); end
    tick();
    idle();
    #1;
    tests_run++;
    if (bus.wb_count !== 16'h0000) begin tests_failed++; $display("FAIL wrap_zero: got %h expected %h", bus.wb_count, 16'h0000); end
    tests_run++;
    if (bus.rs1_data !== 32'h0000C0DE) begin tests_failed++; $display("FAIL wrap_x10: got %h expected %h", bus.rs1_data, 32'h0000C0DE); end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_select();
    test_x0();
    test_bypass();
    test_back_to_back();
    test_counter_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
